serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port start  input  1  SHALL be the request to add a and b, sampled on the rising clk edge.
REQ-005 Port a  input  WIDTH  SHALL be operand A, captured only on an accepted start.
REQ-006 Port b  input  WIDTH  SHALL be operand B, captured only on an accepted start.
REQ-007 Port busy  output  1  SHALL be high while the addition is in progress (state RUN).
REQ-008 Port done  output  1  SHALL be a one-cycle pulse marking the cycle when the result becomes valid.
REQ-009 Port sum  output  WIDTH  SHALL be the registered result, (a+b) mod 2^WIDTH.
REQ-010 Port cout  output  1  SHALL be the registered carry-out, bit WIDTH of a+b.

Function
REQ-011 The adder SHALL be bit-serial: one half-adder pair plus a carry flip-flop SHALL add one bit per clock, LSB first; it SHALL NOT use a WIDTH-bit parallel adder.
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL be accepted: a and b load into shift registers, the carry flip-flop clears to 0, the bit counter clears to 0, and the state becomes RUN.
REQ-014 In RUN, each edge SHALL perform: s_i = a_i ^ b_i ^ c; c <= (a_i&b_i) | (c&(a_i^b_i)); shift s_i into the result register from the MSB side; shift both operand registers right by one bit; increment the counter.
REQ-015 The edge that processes bit WIDTH-1 SHALL move the state from RUN to DONE.
REQ-016 On that same edge, sum SHALL take the full result and cout SHALL take the final carry.
REQ-017 done SHALL be 1 only in state DONE; DONE SHALL last exactly one cycle.
REQ-018 After DONE, the state SHALL go to IDLE unless start=1, in which case it SHALL go straight to RUN (back-to-back accept).
REQ-019 Latency: with start accepted at edge E0, done SHALL be high in the cycle following edge E_WIDTH, i.e. exactly WIDTH cycles of busy=1 followed by one cycle of done=1.
REQ-020 start=1 while in RUN SHALL be ignored; operands, counter and result SHALL NOT be disturbed.
REQ-021 sum and cout SHALL hold their last completed values in IDLE and through a subsequent RUN, updating only on the DONE transition.
REQ-022 a and b changing outside an accepting edge SHALL have no effect.
REQ-023 busy and done SHALL never be high in the same cycle.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force: state IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0 and operand registers 0.
REQ-025 Reset asserted mid-RUN SHALL abandon the operation; no done pulse SHALL follow, and sum and cout SHALL read 0.
REQ-026 After rst deasserts, the first accepted start SHALL behave exactly as in REQ-013.

Verification
REQ-027 WIDTH=8, a=0x00, b=0x00, start pulse -> busy for 8 cycles, then done for 1 cycle, with sum=0x00 and cout=0.
REQ-028 a=0xFF, b=0x01 -> done exactly 9 cycles after the accepting edge, sum=0x00, cout=1; values held through 5 idle cycles.
REQ-029 a=0x5A, b=0x3C -> sum=0x96, cout=0; an exhaustive 4-bit sweep (WIDTH=4, all 256 pairs) SHALL match a+b for every pair.
REQ-030 start re-pulsed with a=0x11, b=0x22 in the third RUN cycle of 0x5A+0x3C -> ignored; result 0x96, and done appears at the original time.
REQ-031 rst pulsed asynchronously (between edges) during RUN -> outputs 0 immediately, no done; the next add of 0x80+0x80 gives sum=0x00, cout=1.
REQ-032 start held high in the DONE cycle with new operands 0x01+0x02 -> no IDLE cycle; the second done follows 8 busy cycles later with sum=0x03.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first,
// and reports the registered sum and carry-out with a one-cycle done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the last completed result
// RUN   | adding one bit per clock, WIDTH cycles in total
// DONE  | result valid for this one cycle; start here chains the next add
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic            carry;
  logic [CW-1:0]   cnt;

  logic ha1_s, ha1_c, ha2_c, s_bit, c_nxt;

  // Two half adders plus the carry flop form the full-adder bit slice.
  assign ha1_s = a_sh[0] ^ b_sh[0];
  assign ha1_c = a_sh[0] & b_sh[0];
  assign s_bit = ha1_s ^ carry;
  assign ha2_c = ha1_s & carry;
  assign c_nxt = ha1_c | ha2_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (busy) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= {s_bit, res_sh[WIDTH-1:1]};
      carry  <= c_nxt;
      cnt    <= cnt + CW'(1);
      // Final bit: publish the completed result with the last sum bit folded in.
      if (cnt == LAST) begin
        sum  <= {s_bit, res_sh[WIDTH-1:1]};
        cout <= c_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random adds
// on an 8-bit instance, and an exhaustive sweep on a 4-bit instance.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8;
  logic [7:0] a8, b8, sum8;
  logic       busy8, done8, cout8;

  logic       start4;
  logic [3:0] a4, b4, sum4;
  logic       busy4, done4, cout4;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] last_sum;
  logic       last_cout;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Present an operand pair with start for one accepting edge.
  task automatic go(input logic [7:0] x, input logic [7:0] y);
    a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  // Called #1 after the accepting edge. Tracks WIDTH busy cycles, then the done cycle.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input int rep,
                        input bit chain, input logic [7:0] nx, input logic [7:0] ny);
    logic [8:0] exp;
    exp = {1'b0, x} + {1'b0, y};
    for (int i = 0; i < 8; i++) begin
      chk("busy", {31'd0, busy8}, 32'd1);
      chk("done_early", {31'd0, done8}, 32'd0);
      chk("sum_hold", {24'd0, sum8}, {24'd0, last_sum});
      chk("cout_hold", {31'd0, cout8}, {31'd0, last_cout});
      if (i == rep) begin
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
      end else begin
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    chk("done", {31'd0, done8}, 32'd1);
    chk("busy_in_done", {31'd0, busy8}, 32'd0);
    chk("sum", {24'd0, sum8}, {24'd0, exp[7:0]});
    chk("cout", {31'd0, cout8}, {31'd0, exp[8]});
    last_sum  = exp[7:0];
    last_cout = exp[8];
    if (chain) begin
      a8 = nx; b8 = ny; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
    end else begin
      @(posedge clk); #1;
      chk("done_one_cycle", {31'd0, done8}, 32'd0);
      chk("idle_busy", {31'd0, busy8}, 32'd0);
    end
  endtask

  initial begin
    logic [7:0] rx, ry;
    logic [4:0] exp4;
    rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    last_sum = '0; last_cout = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_sum", {24'd0, sum8}, 32'd0);
    chk("rst_cout", {31'd0, cout8}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    go(8'h00, 8'h00); run_op(8'h00, 8'h00, -1, 1'b0, 8'h00, 8'h00);

    go(8'hFF, 8'h01); run_op(8'hFF, 8'h01, -1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      chk("idle_sum", {24'd0, sum8}, 32'h00);
      chk("idle_cout", {31'd0, cout8}, 32'd1);
      chk("idle_done", {31'd0, done8}, 32'd0);
      @(posedge clk); #1;
    end

    // Start re-pulsed in the third RUN cycle must be ignored.
    go(8'h5A, 8'h3C); run_op(8'h5A, 8'h3C, 2, 1'b0, 8'h00, 8'h00);

    // Asynchronous reset pulse between edges in the middle of RUN.
    go(8'hC3, 8'h7E);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy8}, 32'd0);
    chk("arst_done", {31'd0, done8}, 32'd0);
    chk("arst_sum", {24'd0, sum8}, 32'd0);
    chk("arst_cout", {31'd0, cout8}, 32'd0);
    #2 rst = 1'b0;
    last_sum = '0; last_cout = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      chk("arst_no_done", {31'd0, done8}, 32'd0);
      chk("arst_no_busy", {31'd0, busy8}, 32'd0);
    end
    go(8'h80, 8'h80); run_op(8'h80, 8'h80, -1, 1'b0, 8'h00, 8'h00);

    // Back-to-back: start held in the DONE cycle.
    go(8'h9D, 8'h44); run_op(8'h9D, 8'h44, -1, 1'b1, 8'h01, 8'h02);
    run_op(8'h01, 8'h02, -1, 1'b0, 8'h00, 8'h00);

    for (int n = 0; n < 20; n++) begin
      rx = 8'($urandom); ry = 8'($urandom);
      go(rx, ry); run_op(rx, ry, -1, 1'b0, 8'h00, 8'h00);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    for (int i = 0; i < 256; i++) begin
      a4 = 4'(i >> 4); b4 = 4'(i);
      exp4 = {1'b0, a4} + {1'b0, b4};
      start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("w4_done", {31'd0, done4}, 32'd1);
      chk("w4_result", {27'd0, cout4, sum4}, {27'd0, exp4});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
